id_ex_pipeline_reg: RTL

Decode-to-execute pipeline register for the pipelined RV32I core. Captures the main decoder's control word plus register-file and immediate data in the decode stage, and presents them to the execute stage one cycle later. It also inserts bubbles for branch/jump flushes and load-use hazards, detects load-use hazards combinationally, and keeps a saturating count of inserted bubbles for debug.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/load_use_detect.sv | 29 ++
 rtl/id_ex_pipeline_reg.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: result-select encodings and the control word
// carried from decode through the E/M and M/W registers.
package pipeline_pkg;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;
  localparam logic [1:0] RESULT_UPC = 2'b11;

  localparam int CTRL_ALU_W = 4;

  typedef struct packed {
    logic                  RegWrite;
    logic [1:0]            ResultSrc;
    logic                  MemWrite;
    logic                  Branch;
    logic                  PcOp;
    logic                  ALUSrc;
    logic [CTRL_ALU_W-1:0] ALUControl;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load sitting in E
// and the instruction in D.
module load_use_detect
  import pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  ValidE,
  input  logic                  RegWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic [ADDR_WIDTH-1:0] RdE,
  input  logic                  ValidD,
  input  logic [ADDR_WIDTH-1:0] Rs1D,
  input  logic [ADDR_WIDTH-1:0] Rs2D,
  output logic                  LoadUseStall
);

  logic load_e;
  logic hit;

  // rs2 is matched even for I-type; a spare bubble is cheaper than decode
  assign load_e = ValidE & RegWriteE
                & (ResultSrcE == RESULT_MEM)
                & (RdE != '0);
  assign hit    = (RdE == Rs1D) | (RdE == Rs2D);

  assign LoadUseStall = load_e & ValidD & hit;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// Decode-to-execute pipeline register with flush/load-use bubbles
// and a saturating bubble counter.
module id_ex_pipeline_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int ALUCTRL_WIDTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallE,
  input  logic                     FlushE,
  input  logic                     ValidD,
  input  logic                     RegWriteD,
  input  logic                     MemWriteD,
  input  logic                     BranchD,
  input  logic                     PcOpD,
  input  logic                     ALUSrcD,
  input  logic [1:0]               ResultSrcD,
  input  logic [ALUCTRL_WIDTH-1:0] ALUControlD,
  input  logic [2:0]               Funct3D,
  input  logic [DATA_WIDTH-1:0]    RD1D,
  input  logic [DATA_WIDTH-1:0]    RD2D,
  input  logic [DATA_WIDTH-1:0]    PCD,
  input  logic [DATA_WIDTH-1:0]    PCPlus4D,
  input  logic [DATA_WIDTH-1:0]    ImmExtD,
  input  logic [ADDR_WIDTH-1:0]    RdD,
  input  logic [ADDR_WIDTH-1:0]    Rs1D,
  input  logic [ADDR_WIDTH-1:0]    Rs2D,
  output logic                     ValidE,
  output logic                     RegWriteE,
  output logic                     MemWriteE,
  output logic                     BranchE,
  output logic                     PcOpE,
  output logic                     ALUSrcE,
  output logic [1:0]               ResultSrcE,
  output logic [ALUCTRL_WIDTH-1:0] ALUControlE,
  output logic [2:0]               Funct3E,
  output logic [DATA_WIDTH-1:0]    RD1E,
  output logic [DATA_WIDTH-1:0]    RD2E,
  output logic [DATA_WIDTH-1:0]    PCE,
  output logic [DATA_WIDTH-1:0]    PCPlus4E,
  output logic [DATA_WIDTH-1:0]    ImmExtE,
  output logic [ADDR_WIDTH-1:0]    RdE,
  output logic [ADDR_WIDTH-1:0]    Rs1E,
  output logic [ADDR_WIDTH-1:0]    Rs2E,
  output logic                     LoadUseStall,
  output logic [CNT_WIDTH-1:0]     BubbleCount
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  bubble;

  assign ctrl_d = '{
    RegWrite:   RegWriteD,
    ResultSrc:  ResultSrcD,
    MemWrite:   MemWriteD,
    Branch:     BranchD,
    PcOp:       PcOpD,
    ALUSrc:     ALUSrcD,
    ALUControl: CTRL_ALU_W'(ALUControlD)
  };

  load_use_detect #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_lud (
    .ValidE       (ValidE),
    .RegWriteE    (RegWriteE),
    .ResultSrcE   (ResultSrcE),
    .RdE          (RdE),
    .ValidD       (ValidD),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .LoadUseStall (LoadUseStall)
  );

  // Flush and load-use together still count as one bubble
  assign bubble = FlushE | LoadUseStall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q      <= CTRL_BUBBLE;
      ValidE      <= 1'b0;
      Funct3E     <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      ImmExtE     <= '0;
      RdE         <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      BubbleCount <= '0;
    end else if (StallE) begin
      ctrl_q <= ctrl_q;
    end else if (bubble) begin
      ctrl_q   <= CTRL_BUBBLE;
      ValidE   <= 1'b0;
      Funct3E  <= '0;
      RD1E     <= '0;
      RD2E     <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      ImmExtE  <= '0;
      RdE      <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      if (BubbleCount != '1) begin
        BubbleCount <= BubbleCount + 1'b1;
      end
    end else begin
      ctrl_q   <= ctrl_d;
      ValidE   <= ValidD;
      Funct3E  <= Funct3D;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      ImmExtE  <= ImmExtD;
      RdE      <= RdD;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
    end
  end

  assign RegWriteE   = ctrl_q.RegWrite;
  assign ResultSrcE  = ctrl_q.ResultSrc;
  assign MemWriteE   = ctrl_q.MemWrite;
  assign BranchE     = ctrl_q.Branch;
  assign PcOpE       = ctrl_q.PcOp;
  assign ALUSrcE     = ctrl_q.ALUSrc;
  assign ALUControlE = ALUCTRL_WIDTH'(ctrl_q.ALUControl);

endmodule
